fp2fx_scheduler: RTL and testbench
==================================

// Module: fp2fx_scheduler
// PURPOSE
//  Shares one float-to-fixed conversion core among N_REQ requesters. Arbitration is round-robin.
//  Accepts one IEEE-754 single plus a per-request fixed-point position, sequences the core and
//  returns the 32-bit two's-complement result tagged with the requester id.
//  Sits between the per-lane producers and the shared converter in the conversion datapath.
// PARAMETERS
//  N_REQ     4   number of requesters (>=2)
//  CORE_LAT  2   core latency in cycles (>=1)
//  ID_W      $clog2(N_REQ)   localparam, requester id width
// PORTS
//  clk         in   1          single clock; all logic on posedge
//  rst         in   1          synchronous, active-high reset
//  req_valid   in   N_REQ      per-requester request valid
//  req_ready   out  N_REQ      per-requester accept (at most one bit high)
//  req_float   in   32*N_REQ   IEEE-754 single; slice i = [32*i+:32]
//  req_fpos    in   5*N_REQ    fractional bits of result; slice i = [5*i+:5]
//  rsp_valid   out  1          result valid
//  rsp_ready   in   1          consumer accepts result
//  rsp_id      out  ID_W       index of the requester that owns the result
//  rsp_result  out  32         signed fixed-point result
//  rsp_ovf     out  1          overflow/special flag; tied 0 unless FP2FX_SAT_EN
//  busy        out  1          high whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_ovf=0, busy=0.
//  FSM states:
//   - IDLE: grant = first i with req_valid[i], searching from rr_ptr upward with wrap.
//     req_ready[grant]=1 (combinational, IDLE only). Handshake fires on valid&ready.
//     On the accepting edge: latch float/fpos/id, start the core, cnt=CORE_LAT-1,
//     rr_ptr=grant+1 (mod N_REQ), go to CONV.
//   - CONV: decrement cnt; when cnt==0, capture the core output into rsp_* and go to HOLD.
//     rsp_valid rises CORE_LAT edges after the accepting edge.
//   - HOLD: rsp_valid=1; rsp_id/result/ovf held stable. On rsp_valid&rsp_ready go to IDLE.
//     The next request is accepted in the following cycle, so the minimum period is CORE_LAT+2 cycles.
//  req_valid may drop without a grant; no request is latched unless the handshake fired.
//  Arithmetic: s, e[7:0], m[22:0]; value = (-1)^s*1.m*2^(e-127).
//   - result = trunc_toward_zero(value*2^fpos) as 32-bit two's complement.
//   - sh = e-150+fpos: left shift {1,m} if sh>=0, right shift otherwise; sh<=-24 gives 0.
//   - e==0 (zero/denormal) gives 0. A negative result is formed by negating the magnitude.
//   - Overflow: magnitude >2^31-1 (s=0) or >2^31 (s=1), or e==255.
//  Reset in CONV/HOLD: in-flight result discarded, rsp_valid low the next cycle, rr_ptr=0.
// CONFIGURATION
//  FP2FX_SAT_EN defined:
//   - on overflow, result = 0x7FFFFFFF (s=0) or 0x80000000 (s=1), and rsp_ovf=1.
//  FP2FX_SAT_EN undefined:
//   - result = low 32 bits of the shifted, signed magnitude (e==255 gives 0x80000000).
//   - rsp_ovf is constant 0.
// STRUCTURE
//  fp2fx_pkg:
//   - state encoding IDLE/CONV/HOLD.
//   - FP_BIAS=127, FP_MAN_W=23, FP_EXP_SPECIAL=255, FIX_MAX=32'h7FFFFFFF, FIX_MIN=32'h80000000.
//  Sub-module fp2fx_core:
//   - inputs start, float, fpos; outputs result, ovf after CORE_LAT registered stages.
//   - no handshake; the scheduler owns all sequencing.
//  Scheduler top: round-robin arbiter, latency counter, response registers.
// TESTING
//  1. req0: 0x3FC00000 (1.5), fpos=4 -> rsp_result=0x00000018, rsp_id=0;
//     rsp_valid exactly CORE_LAT edges after the accept.
//  2. req2: 0xC0100000 (-2.25), fpos=8 -> 0xFFFFFDC0.
//     Then 0xBFE00000 (-1.75), fpos=0 -> 0xFFFFFFFF (toward zero).
//  3. All four req_valid high together from reset, rsp_ready=1 -> grant order 0,1,2,3.
//     Then with req 1 and 3 high -> order 1,3. One req_ready bit at a time.
//  4. rsp_ready low 5 cycles in HOLD -> rsp_* stable, req_ready=0, busy=1.
//     Released -> IDLE next cycle.
//  5. 0x4F000000 (2^31), fpos=0 -> with FP2FX_SAT_EN: 0x7FFFFFFF, ovf=1; without: 0x80000000, ovf=0.
//     Input 0x00000000 -> 0 in both builds.
//  6. rst pulsed in CONV -> rsp_valid never rises for the dropped request, rr_ptr=0;
//     the next request is granted normally.

Source files
------------

// File: rtl/fp2fx_pkg.sv
// Shared types and constants for the float-to-fixed scheduler and its conversion core.
package fp2fx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int          FP_BIAS        = 127;
  localparam int          FP_MAN_W       = 23;
  localparam int          FP_EXP_SPECIAL = 255;
  localparam logic [31:0] FIX_MAX        = 32'h7FFF_FFFF;
  localparam logic [31:0] FIX_MIN        = 32'h8000_0000;

endpackage

// File: rtl/fp2fx_core.sv
// Float-to-fixed conversion core: combinational convert, then CORE_LAT register stages.
// FP2FX_SAT_EN selects saturation with an overflow flag; otherwise results wrap to 32 bits.
module fp2fx_core
  import fp2fx_pkg::*;
#(
  parameter int CORE_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_float,
  input  logic [4:0]  i_fpos,
  output logic [31:0] o_result,
  output logic        o_ovf
);

  logic               w_s;
  logic [7:0]         w_e;
  logic [23:0]        w_man;
  logic signed [10:0] w_sh;
  logic [4:0]         w_nsh;
  logic [31:0]        w_res;
  logic               w_ovf;
`ifdef FP2FX_SAT_EN
  logic [63:0]        w_mag;
`else
  logic [31:0]        w_lo;
`endif

  logic [CORE_LAT-1:0][31:0] r_res;
  logic [CORE_LAT-1:0]       r_ovf;

  always_comb begin
    w_s   = i_float[31];
    w_e   = i_float[30:FP_MAN_W];
    w_man = {1'b1, i_float[FP_MAN_W-1:0]};
    // Shift that lands the mantissa LSB at weight 2^-fpos.
    w_sh  = $signed({3'b000, w_e}) + $signed({6'b000000, i_fpos})
          - $signed(11'(FP_BIAS + FP_MAN_W));
    w_nsh = 5'(-w_sh);
`ifdef FP2FX_SAT_EN
    w_mag = '0;
    if (w_sh >= 0)
      w_mag = {40'd0, w_man} << ((w_sh > 11'sd40) ? 6'd40 : 6'(w_sh));
    else if (w_sh > -11'sd24)
      w_mag = {40'd0, w_man} >> w_nsh;
    w_ovf = (w_e == 8'(FP_EXP_SPECIAL)) ||
            (w_s ? (w_mag > 64'h0000_0000_8000_0000) : (w_mag > 64'h0000_0000_7FFF_FFFF));
    if (w_e == 8'd0) begin
      w_res = '0;
      w_ovf = 1'b0;
    end else if (w_ovf)
      w_res = w_s ? FIX_MIN : FIX_MAX;
    else
      w_res = w_s ? (~w_mag[31:0] + 32'd1) : w_mag[31:0];
`else
    w_lo = '0;
    if (w_sh >= 0) begin
      if (w_sh < 11'sd32) w_lo = {8'd0, w_man} << 5'(w_sh);
    end else if (w_sh > -11'sd24)
      w_lo = {8'd0, w_man} >> w_nsh;
    w_ovf = 1'b0;
    if (w_e == 8'd0)
      w_res = '0;
    else if (w_e == 8'(FP_EXP_SPECIAL))
      w_res = FIX_MIN;
    else
      w_res = w_s ? (~w_lo + 32'd1) : w_lo;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res <= '0;
      r_ovf <= '0;
    end else begin
      if (i_start) begin
        r_res[0] <= w_res;
        r_ovf[0] <= w_ovf;
      end
      for (int k = 1; k < CORE_LAT; k++) begin
        r_res[k] <= r_res[k-1];
        r_ovf[k] <= r_ovf[k-1];
      end
    end
  end

  assign o_result = r_res[CORE_LAT-1];
  assign o_ovf    = r_ovf[CORE_LAT-1];

endmodule

// File: rtl/fp2fx_scheduler.sv
// Round-robin scheduler sharing one fp2fx_core among N_REQ requesters.
// FP2FX_SAT_EN (in the core) enables saturation and the rsp_ovf flag.
module fp2fx_scheduler
  import fp2fx_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int CORE_LAT = 2,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_float,
  input  logic [5*N_REQ-1:0]   req_fpos,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_result,
  output logic                 rsp_ovf,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CORE_LAT + 1);

  state_t            r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_id;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [31:0]       r_rsp_result;
  logic              r_rsp_ovf;

  logic              w_gnt_vld;
  logic [ID_W-1:0]   w_grant;
  logic              w_accept;
  logic [31:0]       w_core_res;
  logic              w_core_ovf;

  // Walk from the highest offset down so the lowest offset past rr_ptr wins.
  always_comb begin
    int idx;
    idx       = 0;
    w_gnt_vld = 1'b0;
    w_grant   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(r_rr_ptr) + k) % N_REQ;
      if (req_valid[idx]) begin
        w_gnt_vld = 1'b1;
        w_grant   = ID_W'(idx);
      end
    end
  end

  assign w_accept = (r_state == IDLE) && w_gnt_vld;

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_grant] = 1'b1;
  end

  fp2fx_core #(.CORE_LAT(CORE_LAT)) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept),
    .i_float  (req_float[32*w_grant +: 32]),
    .i_fpos   (req_fpos[5*w_grant +: 5]),
    .o_result (w_core_res),
    .o_ovf    (w_core_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_id         <= '0;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_gnt_vld) begin
          r_id     <= w_grant;
          r_cnt    <= CNT_W'(CORE_LAT - 1);
          r_rr_ptr <= (w_grant == ID_W'(N_REQ - 1)) ? '0 : w_grant + 1'b1;
          r_state  <= CONV;
        end
        CONV: if (r_cnt == '0) begin
          r_rsp_valid  <= 1'b1;
          r_rsp_id     <= r_id;
          r_rsp_result <= w_core_res;
          r_rsp_ovf    <= w_core_ovf;
          r_state      <= HOLD;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        HOLD: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_ovf    = r_rsp_ovf;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_fp2fx_scheduler.sv
// Directed bench for fp2fx_scheduler: hand-computed vectors checked with immediate assertions.
module tb_fp2fx_scheduler;

  localparam int N_REQ    = 4;
  localparam int CORE_LAT = 2;
  localparam int ID_W     = $clog2(N_REQ);

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_float;
  logic [5*N_REQ-1:0]  req_fpos;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [31:0]         rsp_result;
  logic                rsp_ovf;
  logic                busy;

  int n_vec = 0;
  int n_err = 0;

  fp2fx_scheduler #(.N_REQ(N_REQ), .CORE_LAT(CORE_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_float  (req_float),
    .req_fpos   (req_fpos),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ovf    (rsp_ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int id, input logic [31:0] f, input logic [4:0] p);
    req_float[32*id +: 32] = f;
    req_fpos[5*id +: 5]    = p;
  endtask

  // One full transaction with rsp_ready high; checks grant, latency and payload.
  task automatic txn(input string tag, input int id, input logic [31:0] f, input logic [4:0] p,
                     input logic [31:0] er, input logic eo);
    set_req(id, f, p);
    req_valid     = '0;
    req_valid[id] = 1'b1;
    rsp_ready     = 1'b1;
    #1;
    chk({tag, ".ready"}, 64'(req_ready), 64'(1 << id));
    tick();
    req_valid = '0;
    repeat (CORE_LAT) begin
      chk({tag, ".early"}, 64'(rsp_valid), 64'd0);
      tick();
    end
    chk({tag, ".valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, ".id"}, 64'(rsp_id), 64'(id));
    chk({tag, ".result"}, 64'(rsp_result), 64'(er));
    chk({tag, ".ovf"}, 64'(rsp_ovf), 64'(eo));
    tick();
    chk({tag, ".idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] held;
    rst       = 1'b1;
    req_valid = '0;
    req_float = '0;
    req_fpos  = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst.valid",  64'(rsp_valid),  64'd0);
    chk("rst.id",     64'(rsp_id),     64'd0);
    chk("rst.result", 64'(rsp_result), 64'd0);
    chk("rst.ovf",    64'(rsp_ovf),    64'd0);
    chk("rst.busy",   64'(busy),       64'd0);
    chk("rst.ready",  64'(req_ready),  64'd0);

    txn("t1.1p5",   0, 32'h3FC0_0000, 5'd4, 32'h0000_0018, 1'b0);
    txn("t2.m2p25", 2, 32'hC010_0000, 5'd8, 32'hFFFF_FDC0, 1'b0);
    txn("t2.m1p75", 2, 32'hBFE0_0000, 5'd0, 32'hFFFF_FFFF, 1'b0);
    txn("t2.half",  1, 32'h3F00_0000, 5'd0, 32'h0000_0000, 1'b0);

    // Round-robin: all four valid from reset, then only 1 and 3.
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_req(i, 32'h3F80_0000, 5'(i));
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int g = 0; g < 6; g++) begin
      int eg;
      eg = (g < 4) ? g : ((g == 4) ? 1 : 3);
      if (g == 4) req_valid = 4'b1010;
      #1;
      chk("t3.ready", 64'(req_ready), 64'(1 << eg));
      tick();
      chk("t3.conv_ready", 64'(req_ready), 64'd0);
      repeat (CORE_LAT) tick();
      chk("t3.valid", 64'(rsp_valid), 64'd1);
      chk("t3.id", 64'(rsp_id), 64'(eg));
      chk("t3.result", 64'(rsp_result), 64'(1 << eg));
      tick();
    end
    req_valid = '0;

    // Back-pressure in HOLD.
    set_req(1, 32'h4049_0FDB, 5'd16);
    req_valid[1] = 1'b1;
    rsp_ready    = 1'b0;
    tick();
    req_valid = '0;
    repeat (CORE_LAT) tick();
    set_req(3, 32'h3F80_0000, 5'd0);
    req_valid[3] = 1'b1;
    held = rsp_result;
    chk("t4.pi", 64'(held), 64'h0003_243F);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t4.valid",  64'(rsp_valid),  64'd1);
      chk("t4.result", 64'(rsp_result), 64'(held));
      chk("t4.id",     64'(rsp_id),     64'd1);
      chk("t4.ready",  64'(req_ready),  64'd0);
      chk("t4.busy",   64'(busy),       64'd1);
    end
    rsp_ready = 1'b1;
    tick();
    chk("t4.rel_valid", 64'(rsp_valid), 64'd0);
    chk("t4.rel_busy",  64'(busy),      64'd0);
    chk("t4.rel_ready", 64'(req_ready), 64'b1000);
    req_valid = '0;

    // Overflow and special boundaries.
`ifdef FP2FX_SAT_EN
    txn("t5.2p31",  0, 32'h4F00_0000, 5'd0, 32'h7FFF_FFFF, 1'b1);
    txn("t5.inf",   1, 32'h7F80_0000, 5'd0, 32'h7FFF_FFFF, 1'b1);
`else
    txn("t5.2p31",  0, 32'h4F00_0000, 5'd0, 32'h8000_0000, 1'b0);
    txn("t5.inf",   1, 32'h7F80_0000, 5'd0, 32'h8000_0000, 1'b0);
`endif
    txn("t5.m2p31", 2, 32'hCF00_0000, 5'd0, 32'h8000_0000, 1'b0);
    txn("t5.zero",  3, 32'h0000_0000, 5'd0, 32'h0000_0000, 1'b0);

    // Reset mid-conversion: request from 2 dropped, pointer returns to 0.
    do_reset();
    txn("t6.pre", 1, 32'h3F80_0000, 5'd0, 32'h0000_0001, 1'b0);
    set_req(2, 32'h4000_0000, 5'd0);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    chk("t6.conv_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6.rst_busy", 64'(busy), 64'd0);
    for (int c = 0; c < CORE_LAT + 2; c++) begin
      chk("t6.no_rsp", 64'(rsp_valid), 64'd0);
      tick();
    end
    set_req(0, 32'h4040_0000, 5'd0);
    set_req(3, 32'h3F80_0000, 5'd0);
    req_valid = 4'b1001;
    #1;
    chk("t6.rr0", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    repeat (CORE_LAT) tick();
    chk("t6.valid",  64'(rsp_valid),  64'd1);
    chk("t6.id",     64'(rsp_id),     64'd0);
    chk("t6.result", 64'(rsp_result), 64'd3);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
